// File: rtl/shift_reg_checker_pkg.sv
// Shared constants for the shift-register tester and checker:
// mode codes, logic levels, clock period and checker FSM states.
package shift_reg_checker_pkg;

  localparam logic [1:0] MODO_00 = 2'b00;
  localparam logic [1:0] MODO_01 = 2'b01;
  localparam logic [1:0] MODO_10 = 2'b10;
  localparam logic [1:0] MODO_11 = 2'b11;

  localparam logic HIGH   = 1'b1;
  localparam logic LOW    = 1'b0;
  localparam logic ENABLE = HIGH;

  localparam int CLK_t1 = 10;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'b00,
    ST_CHECK = 2'b01,
    ST_FAIL  = 2'b10
  } state_t;

endpackage

// File: rtl/sr_golden_model.sv
// Cycle-accurate reference of the universal shift register.
// Tracks parallel/serial outputs and whether a load has armed it.
module sr_golden_model
  import shift_reg_checker_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic ENB_ACTIVE = ENABLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] mq,
  output logic             ms,
  output logic             model_valid,
  output logic             load
);

  logic             active;
  logic             exit_bit;
  logic             fill;
  logic [WIDTH-1:0] mq_nxt;
  logic             ms_nxt;

  assign active   = (enb == ENB_ACTIVE);
  assign load     = active && (modo == MODO_10);
  assign exit_bit = (dir == LOW) ? mq[WIDTH-1] : mq[0];
  // Rotate recirculates the bit that leaves; shift takes S_IN.
  assign fill     = (modo == MODO_01) ? exit_bit : s_in;

  always_comb begin
    mq_nxt = mq;
    ms_nxt = ms;
    if (active) begin
      unique case (modo)
        MODO_10: begin
          mq_nxt = d;
          ms_nxt = LOW;
        end
        MODO_00, MODO_01: begin
          ms_nxt = exit_bit;
          if (dir == LOW)
            mq_nxt = {mq[WIDTH-2:0], fill};
          else
            mq_nxt = {fill, mq[WIDTH-1:1]};
        end
        MODO_11: begin
          mq_nxt = mq;
          ms_nxt = ms;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mq          <= '0;
      ms          <= 1'b0;
      model_valid <= 1'b0;
    end else begin
      mq <= mq_nxt;
      ms <= ms_nxt;
      if (load)
        model_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_reg_checker.sv
// Receiver comparing the shift-register DUT against a golden model,
// with mismatch pulse, saturating counters and first-failure capture.
module shift_reg_checker
  import shift_reg_checker_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter logic ENB_ACTIVE = ENABLE,
  parameter int   CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             S_OUT,
  output logic             MISMATCH,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] CHECK_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [WIDTH:0]   FIRST_EXP,
  output logic [WIDTH:0]   FIRST_GOT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             capture;
  logic [WIDTH-1:0] mq;
  logic             ms;
  logic             model_valid;
  logic             load;
  logic [WIDTH:0]   exp_word;
  logic [WIDTH:0]   got_word;
  logic             do_cmp;
  logic             miss;

  sr_golden_model #(
    .WIDTH      (WIDTH),
    .ENB_ACTIVE (ENB_ACTIVE)
  ) u_model (
    .clk         (CLK),
    .reset       (RESET),
    .enb         (ENB),
    .dir         (DIR),
    .s_in        (S_IN),
    .modo        (MODO),
    .d           (D),
    .mq          (mq),
    .ms          (ms),
    .model_valid (model_valid),
    .load        (load)
  );

  // Registered model holds the prediction for the DUT result now on Q.
  assign exp_word = {ms, mq};
  assign got_word = {S_OUT, Q};
  assign do_cmp   = model_valid;
  assign miss     = do_cmp && (got_word !== exp_word);

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= ST_SYNC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      ST_SYNC: begin
        if (load)
          state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (miss) begin
          state_nxt = ST_FAIL;
          capture   = 1'b1;
        end
      end
      ST_FAIL: state_nxt = ST_FAIL;
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MISMATCH    <= 1'b0;
      CHECK_COUNT <= '0;
      ERR_COUNT   <= '0;
      FIRST_EXP   <= '0;
      FIRST_GOT   <= '0;
    end else begin
      MISMATCH <= miss;
      if (do_cmp && (CHECK_COUNT != CNT_MAX))
        CHECK_COUNT <= CHECK_COUNT + CNT_W'(1);
      if (miss && (ERR_COUNT != CNT_MAX))
        ERR_COUNT <= ERR_COUNT + CNT_W'(1);
      if (capture) begin
        FIRST_EXP <= exp_word;
        FIRST_GOT <= got_word;
      end
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_shift_reg_checker.sv
// Bench: a behavioural shift-register DUT with optional faults feeds the
// checker; an arithmetic reference predicts every checker output.
module tb_shift_reg_checker;
  import shift_reg_checker_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enb = 1'b0;
  logic         dir = 1'b0;
  logic         s_in = 1'b0;
  logic [1:0]   modo = 2'b11;
  logic [W-1:0] d = '0;
  logic [W-1:0] q = '0;
  logic         s_out = 1'b0;
  logic         mm;
  logic [1:0]   st;
  logic [7:0]   cc;
  logic [7:0]   ec;
  logic [W:0]   fe;
  logic [W:0]   fg;

  int pass_n = 0;
  int total_n = 0;

  // reference register, fake DUT register, fault selector
  int rq = 0, rs = 0, dq = 0, ds = 0, fault = 0;
  bit rvalid = 0;
  // expected checker outputs
  int e_state = 0, e_cc = 0, e_ec = 0, e_fe = 0, e_fg = 0;
  bit e_mm = 0;

  shift_reg_checker #(
    .WIDTH(W), .ENB_ACTIVE(1'b1), .CNT_W(8)
  ) dut (
    .CLK(clk), .RESET(rst), .ENB(enb), .DIR(dir), .S_IN(s_in),
    .MODO(modo), .D(d), .Q(q), .S_OUT(s_out),
    .MISMATCH(mm), .STATE(st), .CHECK_COUNT(cc), .ERR_COUNT(ec),
    .FIRST_EXP(fe), .FIRST_GOT(fg)
  );

  always #(CLK_t1 / 2) clk = ~clk;

  // returns {serial_out, value} after one edge of a 4-bit register
  function automatic int apply(int v, int s, bit en, bit dr, bit si,
                               int md, int dv);
    int o, f;
    if (!en || md == 3) return (s << 4) | v;
    if (md == 2) return dv & 15;
    o = dr ? (v & 1) : ((v >> 3) & 1);
    f = (md == 1) ? o : int'(si);
    v = dr ? ((v >> 1) | (f << 3)) : (((v << 1) | f) & 15);
    return (o << 4) | v;
  endfunction

  task automatic step(bit r, bit en, bit dr, bit si, int md, int dv);
    int nx, got;
    bit bad;
    @(negedge clk);
    rst = r; enb = en; dir = dr; s_in = si;
    modo = 2'(md); d = W'(dv);
    @(posedge clk);
    got = int'({s_out, q});
    if (r) begin
      e_state = 0; e_cc = 0; e_ec = 0; e_fe = 0; e_fg = 0; e_mm = 0;
      rq = 0; rs = 0; rvalid = 0; dq = 0; ds = 0;
    end else begin
      bad = rvalid && (got != ((rs << 4) | rq));
      e_mm = bad;
      if (rvalid && e_cc < 255) e_cc++;
      if (bad && e_ec < 255) e_ec++;
      if (bad && e_state == 1) begin
        e_state = 2; e_fe = (rs << 4) | rq; e_fg = got;
      end
      if (en && md == 2) begin
        rvalid = 1;
        if (e_state == 0) e_state = 1;
      end
      nx = apply(rq, rs, en, dr, si, md, dv);
      rq = nx & 15; rs = nx >> 4;
      nx = apply(dq, ds, en || fault == 2, dr, si, md, dv);
      dq = nx & 15; ds = nx >> 4;
    end
    #1;
    if (fault == 1) q = W'(dq & 11);
    else if (fault == 3) q = W'(~dq & 15);
    else q = W'(dq);
    s_out = ds[0];
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 3, 0);
    step(1, 0, 0, 0, 3, 0);
    total_n++; if (st !== 2'b00) $display("FAIL reset_state got %0d want 0", st); else pass_n++;
    total_n++; if (cc !== 8'd0) $display("FAIL reset_cc got %0d want 0", cc); else pass_n++;
    total_n++; if (ec !== 8'd0) $display("FAIL reset_ec got %0d want 0", ec); else pass_n++;
    total_n++; if (mm !== 1'b0) $display("FAIL reset_mm got %0d want 0", mm); else pass_n++;
    total_n++; if (fe !== 5'd0 || fg !== 5'd0)
      $display("FAIL reset_capture got %b/%b want 0/0", fe, fg); else pass_n++;
  endtask

  task automatic test_left_shift();
    step(1, 0, 0, 0, 3, 0);
    step(0, 1, 0, 0, 2, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      total_n++; if (mm !== 1'b0) $display("FAIL lshift_mm[%0d] got %0d want 0", i, mm); else pass_n++;
    end
    total_n++; if (cc !== 8'd5) $display("FAIL lshift_cc got %0d want 5", cc); else pass_n++;
    total_n++; if (ec !== 8'd0) $display("FAIL lshift_ec got %0d want 0", ec); else pass_n++;
    total_n++; if (st !== 2'b01) $display("FAIL lshift_state got %0d want 1", st); else pass_n++;
  endtask

  task automatic test_rotate();
    step(0, 1, 0, 0, 2, 8);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 1, 0);
      total_n++; if (mm !== 1'b0) $display("FAIL rotate_mm[%0d] got %0d want 0", i, mm); else pass_n++;
    end
    step(0, 1, 1, 0, 3, 0);
    total_n++; if (mm !== 1'b0) $display("FAIL rotate_last_mm got %0d want 0", mm); else pass_n++;
    total_n++; if (ec !== 8'd0) $display("FAIL rotate_ec got %0d want 0", ec); else pass_n++;
    total_n++; if (cc !== 8'(e_cc)) $display("FAIL rotate_cc got %0d want %0d", cc, e_cc); else pass_n++;
  endtask

  task automatic test_fault();
    fault = 1;
    step(1, 0, 0, 0, 3, 0);
    step(0, 1, 0, 0, 2, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      total_n++; if (mm !== e_mm) $display("FAIL fault_mm[%0d] got %0d want %0d", i, mm, e_mm); else pass_n++;
    end
    total_n++; if (st !== 2'b10) $display("FAIL fault_state got %0d want 2", st); else pass_n++;
    total_n++; if (fe !== 5'b00100) $display("FAIL fault_exp got %b want 00100", fe); else pass_n++;
    total_n++; if (fg !== 5'b00000) $display("FAIL fault_got got %b want 00000", fg); else pass_n++;
    total_n++; if (ec !== 8'd1) $display("FAIL fault_ec got %0d want 1", ec); else pass_n++;
    fault = 0;
  endtask

  task automatic test_enable_gating();
    fault = 2;
    step(1, 0, 0, 0, 3, 0);
    step(0, 1, 0, 0, 2, 6);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    total_n++; if (ec !== 8'd3) $display("FAIL gate_ec got %0d want 3", ec); else pass_n++;
    total_n++; if (fe !== 5'b00110) $display("FAIL gate_exp got %b want 00110", fe); else pass_n++;
    fault = 0;
  endtask

  task automatic test_preload();
    step(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1'($urandom_range(0, 1)), 0, 0);
      total_n++; if (mm !== 1'b0) $display("FAIL preload_mm[%0d] got %0d want 0", i, mm); else pass_n++;
    end
    total_n++; if (st !== 2'b00) $display("FAIL preload_state got %0d want 0", st); else pass_n++;
    total_n++; if (cc !== 8'd0) $display("FAIL preload_cc got %0d want 0", cc); else pass_n++;
  endtask

  task automatic test_reset_mid();
    fault = 3;
    step(1, 0, 0, 0, 3, 0);
    step(0, 1, 0, 0, 2, 9);
    step(0, 1, 0, 0, 3, 0);
    step(0, 1, 0, 0, 3, 0);
    total_n++; if (st !== 2'b10) $display("FAIL mid_pre_state got %0d want 2", st); else pass_n++;
    fault = 0;
    step(1, 0, 0, 0, 3, 0);
    total_n++; if (st !== 2'b00) $display("FAIL mid_state got %0d want 0", st); else pass_n++;
    total_n++; if (cc !== 8'd0 || ec !== 8'd0)
      $display("FAIL mid_counts got %0d/%0d want 0/0", cc, ec); else pass_n++;
    total_n++; if (fe !== 5'd0 || fg !== 5'd0)
      $display("FAIL mid_capture got %b/%b want 0/0", fe, fg); else pass_n++;
    step(0, 1, 0, 0, 2, 5);
    total_n++; if (st !== 2'b01) $display("FAIL mid_rearm got %0d want 1", st); else pass_n++;
    step(0, 1, 0, 0, 3, 0);
    total_n++; if (cc !== 8'd1) $display("FAIL mid_cc got %0d want 1", cc); else pass_n++;
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 3, 0);
    step(0, 1, 0, 0, 2, 5);
    step(0, 1, 0, 0, 2, 10);
    step(0, 1, 0, 0, 2, 3);
    step(0, 1, 0, 0, 3, 0);
    total_n++; if (cc !== 8'd3) $display("FAIL b2b_cc got %0d want 3", cc); else pass_n++;
    total_n++; if (ec !== 8'd0) $display("FAIL b2b_ec got %0d want 0", ec); else pass_n++;
  endtask

  task automatic test_saturation();
    fault = 3;
    step(1, 0, 0, 0, 3, 0);
    step(0, 1, 0, 0, 2, 12);
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15));
    total_n++; if (cc !== 8'd255) $display("FAIL sat_cc got %0d want 255", cc); else pass_n++;
    total_n++; if (ec !== 8'd255) $display("FAIL sat_ec got %0d want 255", ec); else pass_n++;
    total_n++; if (mm !== 1'b1) $display("FAIL sat_mm got %0d want 1", mm); else pass_n++;
    fault = 0;
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) fault = $urandom_range(0, 2);
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 15));
      total_n++;
      if (mm !== e_mm || st !== 2'(e_state) || cc !== 8'(e_cc) ||
          ec !== 8'(e_ec) || fe !== 5'(e_fe) || fg !== 5'(e_fg))
        $display("FAIL random[%0d] got mm%0d st%0d cc%0d ec%0d fe%b fg%b want mm%0d st%0d cc%0d ec%0d fe%b fg%b",
                 i, mm, st, cc, ec, fe, fg, e_mm, e_state, e_cc, e_ec, 5'(e_fe), 5'(e_fg));
      else pass_n++;
    end
    fault = 0;
  endtask

  initial begin
    test_reset();
    test_left_shift();
    test_rotate();
    test_fault();
    test_enable_gating();
    test_preload();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
